// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the data-memory access unit.
// Holds the FSM state encoding, default widths and the fault code.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 8;
  localparam int MEM_DEPTH = 64;
  localparam int WAIT_W    = 4;

  localparam logic FAULT_NONE  = 1'b0;
  localparam logic FAULT_RANGE = 1'b1;

endpackage

// File: rtl/mem_access_unit.sv
// Initiator side of the data-memory interface: one load/store in flight,
// registered memory strobes and a registered response handshake.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W    = mem_access_unit_pkg::DATA_W,
  parameter int ADDR_W    = mem_access_unit_pkg::ADDR_W,
  parameter int MEM_DEPTH = mem_access_unit_pkg::MEM_DEPTH,
  parameter int READ_WAIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // One bit wider than the address so MEM_DEPTH == 2**ADDR_W never faults.
  localparam logic [ADDR_W:0]   LP_DEPTH     = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [WAIT_W-1:0] LP_READ_WAIT = WAIT_W'(READ_WAIT);

  state_t              r_state,      w_state;
  logic                r_req_ready,  w_req_ready;
  logic                r_resp_valid, w_resp_valid;
  logic [DATA_W-1:0]   r_resp_rdata, w_resp_rdata;
  logic                r_resp_fault, w_resp_fault;
  logic                r_mem_we,     w_mem_we;
  logic                r_mem_re,     w_mem_re;
  logic [ADDR_W-1:0]   r_mem_addr,   w_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata,  w_mem_wdata;
  logic [WAIT_W-1:0]   r_wait_cnt,   w_wait_cnt;
  logic                w_addr_fault;

  assign w_addr_fault = ({1'b0, req_addr} >= LP_DEPTH);

  // Next-state and next-output logic; every output is a register image.
  always_comb begin
    w_state      = r_state;
    w_req_ready  = r_req_ready;
    w_resp_valid = r_resp_valid;
    w_resp_rdata = r_resp_rdata;
    w_resp_fault = r_resp_fault;
    w_mem_we     = r_mem_we;
    w_mem_re     = r_mem_re;
    w_mem_addr   = r_mem_addr;
    w_mem_wdata  = r_mem_wdata;
    w_wait_cnt   = r_wait_cnt;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_req_ready = 1'b0;
          w_mem_addr  = req_addr;
          w_mem_wdata = req_wdata;
          if (w_addr_fault) begin
            w_state      = ST_RESP;
            w_resp_valid = 1'b1;
            w_resp_fault = FAULT_RANGE;
            w_resp_rdata = {DATA_W{1'b0}};
          end else if (req_write) begin
            w_state  = ST_WRITE;
            w_mem_we = 1'b1;
          end else begin
            w_state    = ST_READ;
            w_mem_re   = 1'b1;
            w_wait_cnt = LP_READ_WAIT;
          end
        end else begin
          w_req_ready = 1'b1;
        end
      end
      ST_WRITE: begin
        w_state      = ST_RESP;
        w_mem_we     = 1'b0;
        w_resp_valid = 1'b1;
        w_resp_rdata = {DATA_W{1'b0}};
        w_resp_fault = FAULT_NONE;
      end
      ST_READ: begin
        if (r_wait_cnt != {WAIT_W{1'b0}}) begin
          w_wait_cnt = r_wait_cnt - {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
          w_state      = ST_RESP;
          w_mem_re     = 1'b0;
          w_resp_valid = 1'b1;
          w_resp_rdata = mem_rdata;
          w_resp_fault = FAULT_NONE;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          w_state      = ST_IDLE;
          w_resp_valid = 1'b0;
          w_req_ready  = 1'b1;
        end else begin
          w_resp_valid = 1'b1;
        end
      end
      default: begin
        w_state      = ST_IDLE;
        w_req_ready  = 1'b1;
        w_resp_valid = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_re     = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= {DATA_W{1'b0}};
      r_resp_fault <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_re     <= 1'b0;
      r_mem_addr   <= {ADDR_W{1'b0}};
      r_mem_wdata  <= {DATA_W{1'b0}};
      r_wait_cnt   <= {WAIT_W{1'b0}};
    end else begin
      r_state      <= w_state;
      r_req_ready  <= w_req_ready;
      r_resp_valid <= w_resp_valid;
      r_resp_rdata <= w_resp_rdata;
      r_resp_fault <= w_resp_fault;
      r_mem_we     <= w_mem_we;
      r_mem_re     <= w_mem_re;
      r_mem_addr   <= w_mem_addr;
      r_mem_wdata  <= w_mem_wdata;
      r_wait_cnt   <= w_wait_cnt;
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_fault = r_resp_fault;
  assign mem_we     = r_mem_we;
  assign mem_re     = r_mem_re;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule
